wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

- Shares the single register-file write port between the in-order writeback stage and the multi-cycle mul/div unit.
- Mul/div results are held in a small in-order queue and drained into idle writeback slots.
- A starvation counter forces a drain, and stalls writeback, if the queue waits too long.
- Enforces write-after-write ordering: a younger pipeline write to a queued destination cancels the stale queued result.

## Interface
Parameters:
- XLEN, 64, register data width (matches word_t)
- DEPTH, 2, mul/div result queue entries (power of two, ≥2)
- STARVE, 4, consecutive cycles a non-empty queue may be denied before a forced drain

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback stage holds a valid instruction
- wb_regwrite  in  1  that instruction writes a register (ctl.regwrite)
- wb_dst  in  5  destination register
- wb_data  in  XLEN  result, already muxed between ALU and load data
- md_valid  in  1  mul/div result offered
- md_dst  in  5  mul/div destination
- md_data  in  XLEN  mul/div result
- md_ready  out  1  queue accepts md offer this cycle
- wb_stall  out  1  writeback slot denied; pipeline must hold the writeback stage
- rf_wen  out  1  register-file write enable
- rf_wa  out  5  write address
- rf_wd  out  XLEN  write data

## Operation
- Queue:
  - Circular FIFO with head/tail pointers, count 0..DEPTH and a per-entry live bit.
  - Enqueue when md_valid && md_ready; md_ready = (count < DEPTH), computed from registered count only.
  - md_dst == 0 is accepted and discarded, never enqueued.
- wb request: wb_req = wb_valid && wb_regwrite && wb_dst != 0.
- Grant policy, evaluated each cycle:
  - If the head entry is dead (live=0), pop it silently with no port use; this costs one cycle.
  - Otherwise, if starve_cnt == STARVE-1 and the queue is non-empty, grant the queue. If wb_req is also high, assert wb_stall.
  - Otherwise, if wb_req, grant wb and starve_cnt increments when the queue is non-empty.
  - Otherwise, if the queue is non-empty, grant the queue.
- starve_cnt:
  - Resets to 0 on any queue grant or when the queue is empty.
  - Saturates at STARVE-1.
- WAW kill: on a granted wb write, every live queued entry with dst == wb_dst gets live cleared in the same cycle.
- Outputs:
  - Queue grant: rf_wen=1, rf_wa/rf_wd = head entry; the entry pops at the clock edge.
  - wb grant: rf_wen=1, rf_wa/rf_wd = wb_dst/wb_data.
  - No grant: rf_wen=0 and rf_wa/rf_wd = 0.

## Timing
- Reset values:
  - count=0, pointers=0, all live=0, starve_cnt=0.
  - md_ready=1, wb_stall=0, rf_wen=0, rf_wa=0, rf_wd=0.
- Reset mid-operation flushes the queue; queued results are lost by design.
- rf_* and wb_stall are combinational from inputs and state, so a wb write reaches the port in the same cycle.
- Enqueued entry is eligible for grant no earlier than the cycle after acceptance; there is no bypass.
- Full queue with a pop in the same cycle: md_ready stays 0 that cycle and rises the next cycle.
- Enqueue and pop in the same cycle: count unchanged.
- WAW kill and enqueue in the same cycle with equal dst: the new entry is enqueued live, because it is older than nothing queued later.
- wb_stall is held while the forced grant proceeds. The stalled wb request wins the following cycle, since starve_cnt has returned to 0.

## Structure
- Add to pipes package:
  - typedef md_result_t {dst, data}
  - typedef wbq_entry_t {live, dst, data}
- Add to common package:
  - localparam WBQ_DEPTH
  - localparam WBQ_STARVE
- Natural sub-module: wbq_fifo, holding storage, pointers, count and the per-entry live-bit kill port.
- Grant and starvation logic stays in wb_port_arbiter.

## Test plan
- Reset asserted, no requests → md_ready=1, rf_wen=0, wb_stall=0.
- wb_req only, dst=5, data=0x1234 → rf_wen=1, rf_wa=5, rf_wd=0x1234 the same cycle.
- md dst=7, data=0xAA with wb idle → accepted at cycle 0, written at cycle 1, count back to 0.
- Fill 2 entries, then keep wb_req high → md_ready=0. Queue starves for 3 cycles; 4th cycle grants the queue head with wb_stall=1. Next cycle wb writes.
- Queue holds dst=3 and wb writes dst=3 → rf shows wb value. Queued entry is popped dead later with rf_wen=0, and the final x3 equals the wb value.
- md dst=0 and wb dst=0 → never written (rf_wen=0); md accepted with count unchanged.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned WBQ_DEPTH  = 2;
  localparam int unsigned WBQ_STARVE = 4;

  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [REG_AW-1:0]   reg_addr_t;

  // Mul/div result as offered to the arbiter
  typedef struct packed {
    reg_addr_t dst;
    word_t     data;
  } md_result_t;

  // One queued mul/div result; live drops when a younger write supersedes it
  typedef struct packed {
    logic      live;
    reg_addr_t dst;
    word_t     data;
  } wbq_entry_t;

  // Who owns the register-file write port this cycle
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WB    = 2'd1,
    GNT_QUEUE = 2'd2,
    GNT_DROP  = 2'd3
  } grant_t;

endpackage

// File: rtl/wbq_fifo.sv
// In-order mul/div result queue with per-entry live bits and a WAW kill port.
module wbq_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  reg_addr_t                    push_dst,
  input  logic [XLEN-1:0]              push_data,
  input  logic                         pop,
  input  logic                         kill,
  input  reg_addr_t                    kill_dst,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_live,
  output reg_addr_t                    head_dst,
  output logic [XLEN-1:0]              head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] live;
  reg_addr_t        dst_q  [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointers, count and live bits; kill applies to stored entries, then pop/push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (kill && live[i] && (dst_q[i] == kill_dst)) begin
          live[i] <= 1'b0;
        end
      end
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + PTR_W'(1);
      end
      if (push) begin
        live[tail] <= 1'b1;
        tail       <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents are only meaningful while the slot is occupied
  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[tail]  <= push_dst;
      data_q[tail] <= push_data;
    end
  end

  assign head_live = live[head] && (count != '0);
  assign head_dst  = dst_q[head];
  assign head_data = data_q[head];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between writeback and queued mul/div results.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned DEPTH  = WBQ_DEPTH,
  parameter int unsigned STARVE = WBQ_STARVE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_dst,
  input  logic [XLEN-1:0] wb_data,
  input  logic            md_valid,
  input  logic [4:0]      md_dst,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  output logic            wb_stall,
  output logic            rf_wen,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SC_W  = (STARVE > 1) ? $clog2(STARVE) : 1;

  logic [CNT_W-1:0] count;
  logic             head_live;
  reg_addr_t        head_dst;
  logic [XLEN-1:0]  head_data;
  logic [SC_W-1:0]  starve_cnt;
  grant_t           grant;
  logic             wb_req;
  logic             q_nonempty;
  logic             starved;
  logic             push;
  logic             pop;
  logic             kill;

  wbq_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_dst  (md_dst),
    .push_data (md_data),
    .pop       (pop),
    .kill      (kill),
    .kill_dst  (wb_dst),
    .count     (count),
    .head_live (head_live),
    .head_dst  (head_dst),
    .head_data (head_data)
  );

  // Grant decision: dead-head drop, forced drain, writeback, then idle drain
  always_comb begin
    grant      = GNT_NONE;
    wb_stall   = 1'b0;
    wb_req     = wb_valid && wb_regwrite && (wb_dst != 5'd0);
    q_nonempty = (count != '0);
    starved    = (starve_cnt == SC_W'(STARVE - 1));
    if (q_nonempty && !head_live) begin
      grant    = GNT_DROP;
      wb_stall = wb_req;
    end else if (q_nonempty && starved) begin
      grant    = GNT_QUEUE;
      wb_stall = wb_req;
    end else if (wb_req) begin
      grant = GNT_WB;
    end else if (q_nonempty) begin
      grant = GNT_QUEUE;
    end
  end

  // Port drive and queue control derived from the grant
  always_comb begin
    rf_wen   = 1'b0;
    rf_wa    = '0;
    rf_wd    = '0;
    md_ready = (count < CNT_W'(DEPTH));
    push     = md_valid && md_ready && (md_dst != 5'd0);
    pop      = (grant == GNT_QUEUE) || (grant == GNT_DROP);
    kill     = (grant == GNT_WB);
    case (grant)
      GNT_WB: begin
        rf_wen = 1'b1;
        rf_wa  = wb_dst;
        rf_wd  = wb_data;
      end
      GNT_QUEUE: begin
        rf_wen = 1'b1;
        rf_wa  = head_dst;
        rf_wd  = head_data;
      end
      default: begin
        rf_wen = 1'b0;
      end
    endcase
  end

  // Starvation counter: counts writeback wins over a waiting queue, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!q_nonempty || (grant == GNT_QUEUE)) begin
      starve_cnt <= '0;
    end else if ((grant == GNT_WB) && !starved) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic.
module tb_wb_port_arbiter;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_valid, wb_regwrite, md_valid;
  logic [4:0]      wb_dst, md_dst;
  logic [XLEN-1:0] wb_data, md_data;
  logic            md_ready, wb_stall, rf_wen;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .md_valid(md_valid), .md_dst(md_dst), .md_data(md_data),
    .md_ready(md_ready), .wb_stall(wb_stall),
    .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  typedef struct {
    logic [4:0]  dst;
    logic [63:0] data;
    bit          live;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  int          step_no = 0;
  ent_t        mq[$];
  int          m_starve = 0;
  logic [63:0] shadow [32];
  bit          last_stall = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s step=%0d got=%0h exp=%0h", tag, step_no, got, exp);
    end
  endtask

  // Drive one cycle, predict from the queue model, compare, advance the clock
  task automatic step(input logic wv, input logic wr, input logic [4:0] wdst,
                      input logic [63:0] wdat, input logic mv, input logic [4:0] mdst,
                      input logic [63:0] mdat);
    bit          req;
    int          n;
    bit          e_ready, e_stall, e_wen;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    ent_t        ne;
    wb_valid = wv; wb_regwrite = wr; wb_dst = wdst; wb_data = wdat;
    md_valid = mv; md_dst = mdst; md_data = mdat;
    #4;
    req = wv && wr && (wdst != 5'd0);
    n = mq.size();
    e_ready = (n < DEPTH);
    e_stall = 0; e_wen = 0; e_wa = '0; e_wd = '0;
    if (n > 0 && !mq[0].live) begin
      e_stall = req;
      void'(mq.pop_front());
    end else if (n > 0 && m_starve == STARVE - 1) begin
      e_wen = 1; e_wa = mq[0].dst; e_wd = mq[0].data; e_stall = req;
      void'(mq.pop_front());
      m_starve = 0;
    end else if (req) begin
      e_wen = 1; e_wa = wdst; e_wd = wdat;
      foreach (mq[i]) if (mq[i].dst == wdst) mq[i].live = 0;
      if (n > 0 && m_starve < STARVE - 1) m_starve++;
    end else if (n > 0) begin
      e_wen = 1; e_wa = mq[0].dst; e_wd = mq[0].data;
      void'(mq.pop_front());
      m_starve = 0;
    end
    if (n == 0) m_starve = 0;
    if (mv && e_ready && mdst != 5'd0) begin
      ne.dst = mdst; ne.data = mdat; ne.live = 1;
      mq.push_back(ne);
    end
    check("md_ready", 64'(md_ready), 64'(e_ready));
    check("wb_stall", 64'(wb_stall), 64'(e_stall));
    check("rf_wen",   64'(rf_wen),   64'(e_wen));
    check("rf_wa",    64'(rf_wa),    64'(e_wa));
    check("rf_wd",    rf_wd,         e_wd);
    if (rf_wen) shadow[rf_wa] = rf_wd;
    last_stall = e_stall;
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
  endtask

  // Assert reset asynchronously, check the reset outputs, drop the model queue
  task automatic apply_reset();
    wb_valid = 0; wb_regwrite = 0; wb_dst = '0; wb_data = '0;
    md_valid = 0; md_dst = '0; md_data = '0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_md_ready", 64'(md_ready), 64'd1);
    check("rst_wb_stall", 64'(wb_stall), 64'd0);
    check("rst_rf_wen",   64'(rf_wen),   64'd0);
    check("rst_rf_wa",    64'(rf_wa),    64'd0);
    check("rst_rf_wd",    rf_wd,         64'd0);
    mq.delete();
    m_starve = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic        wv, wr, mv;
    logic [4:0]  wd, mdd;
    logic [63:0] wdat, mdat;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply_reset();

    // Plain writeback goes straight to the port
    step(1, 1, 5'd5, 64'h1234, 0, 5'd0, 64'd0);

    // Lone mul/div result: accepted, drained next cycle, queue empty after
    step(0, 0, 5'd0, 64'd0, 1, 5'd7, 64'hAA);
    idle();
    idle();

    // Fill the queue under constant writeback, then forced drain with stall
    step(1, 1, 5'd1, 64'h101, 1, 5'd8, 64'h808);
    step(1, 1, 5'd2, 64'h102, 1, 5'd9, 64'h909);
    step(1, 1, 5'd4, 64'h104, 1, 5'd10, 64'hA0A);
    step(1, 1, 5'd4, 64'h105, 0, 5'd0, 64'd0);
    step(1, 1, 5'd4, 64'h106, 0, 5'd0, 64'd0);
    step(1, 1, 5'd4, 64'h106, 0, 5'd0, 64'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 5'd4, 64'h200 + 64'(i), 0, 5'd0, 64'd0);
    for (int i = 0; i < 3; i++) idle();

    // Younger writeback to a queued destination kills the stale result
    step(1, 1, 5'd1, 64'h111, 1, 5'd3, 64'h33);
    step(1, 1, 5'd3, 64'h5555, 0, 5'd0, 64'd0);
    idle();
    idle();
    check("x3_final", shadow[3], 64'h5555);

    // Same-cycle kill and enqueue to the same destination keeps the new entry
    step(1, 1, 5'd6, 64'h66, 1, 5'd6, 64'h6677);
    idle();
    check("x6_final", shadow[6], 64'h6677);

    // Writes to x0 never reach the port; md offer still accepted
    step(1, 1, 5'd0, 64'hDEAD, 1, 5'd0, 64'hBEEF);
    idle();

    // Random traffic; a stalled writeback holds its instruction
    wv = 0; wr = 0; wd = '0; wdat = '0;
    for (int c = 0; c < 400; c++) begin
      if (!last_stall) begin
        wv   = ($urandom_range(0, 3) != 0);
        wr   = ($urandom_range(0, 4) != 0);
        wd   = 5'($urandom_range(0, 7));
        wdat = {$urandom, $urandom};
      end
      mv   = ($urandom_range(0, 1) != 0);
      mdd  = 5'($urandom_range(0, 7));
      mdat = {$urandom, $urandom};
      step(wv, wr, wd, wdat, mv, mdd, mdat);
    end

    // Reset with results still queued: they are dropped
    step(1, 1, 5'd1, 64'h1, 1, 5'd12, 64'hC0C);
    step(1, 1, 5'd2, 64'h2, 1, 5'd13, 64'hD0D);
    apply_reset();
    idle();
    idle();
    check("x12_lost", shadow[12], 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
